// File: rtl/tbec_scrubber_pkg.sv
// tbec_pkg: shared definitions for the ECC memory scrubber.
//   - default address/data widths and counter width
//   - error-code enum reported by the ECC memory (tbec_full)
//   - scrubber FSM state enum
//   - helper deciding whether a code means "not correctable"
package tbec_pkg;

    localparam int unsigned TBEC_ADDR_W = 8;
    localparam int unsigned TBEC_DATA_W = 16;
    localparam int unsigned TBEC_CNT_W  = 16;

    typedef enum logic [1:0] {
        TBEC_OK     = 2'b00,
        TBEC_CORR   = 2'b01,
        TBEC_UNCORR = 2'b10,
        TBEC_RSVD   = 2'b11
    } tbec_code_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EVAL = 3'd3,
        S_WB   = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } tbec_state_e;

    // The reserved code is handled exactly like an uncorrectable one, so
    // both codes with the upper bit set count as uncorrectable.
    function automatic logic code_is_uncorr(input tbec_code_e code);
        return code[1];
    endfunction

endpackage

// File: rtl/tbec_scrubber_if.sv
// Bus interfaces of the scrubber.
//   tbec_host_if : host access request toward the ECC memory
//       host_addr / host_we / host_wdata  (host -> scrubber)
//       host_gnt                          (scrubber -> host), 1 while host owns the port
//   tbec_mem_if  : port of the ECC memory (tbec_full)
//       tbec_addr / mem_we / data_in      (scrubber -> memory)
//       data_out / out_error_code         (memory -> scrubber), corrected data + code
interface tbec_host_if #(
    parameter int unsigned ADDR_W = tbec_pkg::TBEC_ADDR_W,
    parameter int unsigned DATA_W = tbec_pkg::TBEC_DATA_W
) ();
    logic [ADDR_W-1:0] host_addr;
    logic              host_we;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;

    modport master (output host_addr, output host_we, output host_wdata, input  host_gnt);
    modport slave  (input  host_addr, input  host_we, input  host_wdata, output host_gnt);
endinterface

interface tbec_mem_if #(
    parameter int unsigned ADDR_W = tbec_pkg::TBEC_ADDR_W,
    parameter int unsigned DATA_W = tbec_pkg::TBEC_DATA_W
) ();
    logic [ADDR_W-1:0] tbec_addr;
    logic              mem_we;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        out_error_code;

    modport master (output tbec_addr, output mem_we, output data_in,
                    input  data_out,  input  out_error_code);
    modport slave  (input  tbec_addr, input  mem_we, input  data_in,
                    output data_out,  output out_error_code);
endinterface

// File: rtl/tbec_sat_cnt.sv
// tbec_sat_cnt: W-bit counter with synchronous clear and saturating increment.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : add one unless already all-ones
//   cnt      : current count (registered)
module tbec_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tbec_scrubber.sv
// tbec_scrubber: walks an ECC memory from address 0 to LAST_ADDR, reads each
// word, writes back words that came back corrected and records uncorrectable
// locations. While idle the memory port is handed straight to the host.
//   tbec_clk, tbec_rst   : clock, asynchronous active-high reset
//   start / abort        : begin a pass (pulse) / end it early (level)
//   host (slave)         : host request, host_gnt=1 while idle
//   mem (master)         : ECC memory port
//   busy / done          : pass in progress / one-cycle completion pulse
//   corr_cnt, uncorr_cnt : per-pass error counters (saturating)
//   last_uncorr_addr, uncorr_flag : sticky uncorrectable record
module tbec_scrubber
    import tbec_pkg::*;
#(
    parameter int unsigned       ADDR_W    = TBEC_ADDR_W,
    parameter int unsigned       DATA_W    = TBEC_DATA_W,
    parameter int unsigned       READ_LAT  = 1,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                  tbec_clk,
    input  logic                  tbec_rst,
    input  logic                  start,
    input  logic                  abort,
    tbec_host_if.slave            host,
    tbec_mem_if.master            mem,
    output logic                  busy,
    output logic                  done,
    output logic [TBEC_CNT_W-1:0] corr_cnt,
    output logic [TBEC_CNT_W-1:0] uncorr_cnt,
    output logic [ADDR_W-1:0]     last_uncorr_addr,
    output logic                  uncorr_flag
);

    // WAIT lasts READ_LAT cycles; the counter runs 0 .. READ_LAT-1.
    localparam logic [1:0]        WAIT_LAST = 2'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    tbec_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    tbec_code_e        rd_code_q, rd_code_d;
    logic [ADDR_W-1:0] last_uncorr_q, last_uncorr_d;
    logic              uncorr_flag_q, uncorr_flag_d;
    logic              cnt_clr_s;
    logic              corr_inc_s;
    logic              uncorr_inc_s;

    // State and datapath registers
    always_ff @(posedge tbec_clk or posedge tbec_rst) begin
        if (tbec_rst) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= {ADDR_W{1'b0}};
            wait_cnt_q    <= 2'd0;
            rd_data_q     <= {DATA_W{1'b0}};
            rd_code_q     <= TBEC_OK;
            last_uncorr_q <= {ADDR_W{1'b0}};
            uncorr_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_code_q     <= rd_code_d;
            last_uncorr_q <= last_uncorr_d;
            uncorr_flag_q <= uncorr_flag_d;
        end
    end

    // Next-state logic, address walk and read capture
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        wait_cnt_d = wait_cnt_q;
        rd_data_d  = rd_data_q;
        rd_code_d  = rd_code_q;
        case (state_q)
            S_IDLE: begin
                // abort in the same cycle as start keeps the port with the host
                if (start && !abort) begin
                    state_d    = S_RD;
                    cur_addr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                wait_cnt_d = 2'd0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    rd_data_d = mem.data_out;
                    rd_code_d = tbec_code_e'(mem.out_error_code);
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EVAL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rd_code_q == TBEC_CORR) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WB: begin
                // the write issued this cycle always lands; abort only skips NEXT
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cur_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_RD;
                    cur_addr_d = cur_addr_q + ADDR_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Error accounting: EVAL's verdict is booked even if abort arrives with it
    always_comb begin
        last_uncorr_d = last_uncorr_q;
        uncorr_flag_d = uncorr_flag_q;
        corr_inc_s    = 1'b0;
        uncorr_inc_s  = 1'b0;
        if ((state_q == S_IDLE) && start && !abort) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
        if (state_q == S_EVAL) begin
            corr_inc_s   = (rd_code_q == TBEC_CORR);
            uncorr_inc_s = code_is_uncorr(rd_code_q);
            if (uncorr_inc_s) begin
                last_uncorr_d = cur_addr_q;
                uncorr_flag_d = 1'b1;
            end else begin
                last_uncorr_d = last_uncorr_q;
                uncorr_flag_d = uncorr_flag_q;
            end
        end else begin
            corr_inc_s   = 1'b0;
            uncorr_inc_s = 1'b0;
        end
    end

    // Output decode: host pass-through in IDLE, scrubber drives the port otherwise
    always_comb begin
        host.host_gnt = 1'b0;
        mem.tbec_addr = cur_addr_q;
        mem.mem_we    = 1'b0;
        mem.data_in   = rd_data_q;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                host.host_gnt = 1'b1;
                mem.tbec_addr = host.host_addr;
                mem.mem_we    = host.host_we;
                mem.data_in   = host.host_wdata;
            end
            S_RD, S_WAIT, S_EVAL, S_NEXT: begin
                busy = 1'b1;
            end
            S_WB: begin
                busy       = 1'b1;
                mem.mem_we = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    tbec_sat_cnt #(.W(TBEC_CNT_W)) u_corr_cnt (
        .clk (tbec_clk),
        .rst (tbec_rst),
        .clr (cnt_clr_s),
        .inc (corr_inc_s),
        .cnt (corr_cnt)
    );

    tbec_sat_cnt #(.W(TBEC_CNT_W)) u_uncorr_cnt (
        .clk (tbec_clk),
        .rst (tbec_rst),
        .clr (cnt_clr_s),
        .inc (uncorr_inc_s),
        .cnt (uncorr_cnt)
    );

    assign last_uncorr_addr = last_uncorr_q;
    assign uncorr_flag      = uncorr_flag_q;

endmodule

// File: tb/tb_tbec_scrubber.sv
`timescale 1ns/1ps
// Bench for tbec_scrubber with a behavioural ECC memory. A pass is modelled as
// a list of expected port cycles derived from the per-address cost rule
// (RD, READ_LAT waits, EVAL, optional write-back, NEXT, then DONE).
module tb_tbec_scrubber;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int RL    = 1;
    localparam int NADDR = 256;
    localparam logic [7:0] LAST = 8'hFF;

    logic tbec_clk = 1'b0;
    logic tbec_rst = 1'b1;
    logic start    = 1'b0;
    logic abort    = 1'b0;
    logic busy, done, uncorr_flag;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic [7:0]  last_uncorr_addr;

    always #5 tbec_clk = ~tbec_clk;

    tbec_host_if #(.ADDR_W(AW), .DATA_W(DW)) host_bus ();
    tbec_mem_if  #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    tbec_scrubber #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .LAST_ADDR(LAST)) dut (
        .tbec_clk         (tbec_clk),
        .tbec_rst         (tbec_rst),
        .start            (start),
        .abort            (abort),
        .host             (host_bus.slave),
        .mem              (mem_bus.master),
        .busy             (busy),
        .done             (done),
        .corr_cnt         (corr_cnt),
        .uncorr_cnt       (uncorr_cnt),
        .last_uncorr_addr (last_uncorr_addr),
        .uncorr_flag      (uncorr_flag)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural ECC memory (READ_LAT = 1) ----------------
    logic [DW-1:0] mem_arr [NADDR];
    logic [1:0]    err_arr [NADDR];
    logic          bd_valid = 1'b0;
    logic [7:0]    bd_addr  = 8'h00;
    logic [DW-1:0] bd_data  = 16'h0000;
    logic [1:0]    bd_err   = 2'b00;
    int            n_writes = 0;
    logic [7:0]    last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int            done_seen = 0;

    always @(posedge tbec_clk) begin : mem_model
        if (bd_valid) begin
            mem_arr[bd_addr] <= bd_data;
            err_arr[bd_addr] <= bd_err;
        end
        if (mem_bus.mem_we) begin
            mem_arr[mem_bus.tbec_addr] <= mem_bus.data_in;
            err_arr[mem_bus.tbec_addr] <= 2'b00;
            n_writes     <= n_writes + 1;
            last_wr_addr <= mem_bus.tbec_addr;
            last_wr_data <= mem_bus.data_in;
        end
        // uncorrectable words come back garbled
        mem_bus.data_out       <= err_arr[mem_bus.tbec_addr][1] ?
                                  (mem_arr[mem_bus.tbec_addr] ^ 16'h0F0F) : mem_arr[mem_bus.tbec_addr];
        mem_bus.out_error_code <= err_arr[mem_bus.tbec_addr];
    end

    always @(negedge tbec_clk) if (done === 1'b1) done_seen <= done_seen + 1;

    // ---------------- reference model ----------------
    typedef struct {
        bit         busy;
        bit         done;
        bit         we;
        bit         eval;
        logic [1:0] code;
        logic [7:0] addr;
        logic [15:0] wdata;
    } rec_t;

    rec_t        plan[$];
    logic [15:0] exp_corr   = 16'h0000;
    logic [15:0] exp_uncorr = 16'h0000;
    logic [7:0]  exp_last   = 8'h00;
    logic        exp_flag   = 1'b0;

    function automatic rec_t mk(bit b, bit d, bit w, bit e, logic [1:0] c, logic [7:0] a, logic [15:0] wd);
        rec_t r;
        r.busy = b; r.done = d; r.we = w; r.eval = e; r.code = c; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    // Expected cycles of a full pass, from the memory contents at start time.
    function automatic void build_plan();
        plan.delete();
        for (int a = 0; a <= int'(LAST); a++) begin
            logic [1:0] c;
            c = err_arr[a];
            plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'(a), 16'h0000));
            for (int w = 0; w < RL; w++) plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'(a), 16'h0000));
            plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, c, 8'(a), 16'h0000));
            if (c == 2'b01) plan.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'(a), mem_arr[a]));
            plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'(a), 16'h0000));
        end
        plan.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, LAST, 16'h0000));
    endfunction

    function automatic void model_reset();
        plan.delete();
        exp_corr = 16'h0000; exp_uncorr = 16'h0000; exp_last = 8'h00; exp_flag = 1'b0;
    endfunction

    task automatic compare();
        if (plan.size() != 0) begin
            rec_t r;
            r = plan[0];
            chk("host_gnt", host_bus.host_gnt, 1'b0);
            chk("busy", busy, r.busy);
            chk("done", done, r.done);
            chk("tbec_addr", mem_bus.tbec_addr, r.addr);
            chk("mem_we", mem_bus.mem_we, r.we);
            if (r.we) chk("data_in", mem_bus.data_in, r.wdata);
        end else begin
            chk("host_gnt", host_bus.host_gnt, 1'b1);
            chk("busy", busy, 1'b0);
            chk("done", done, 1'b0);
            chk("tbec_addr", mem_bus.tbec_addr, host_bus.host_addr);
            chk("mem_we", mem_bus.mem_we, host_bus.host_we);
            chk("data_in", mem_bus.data_in, host_bus.host_wdata);
        end
        chk("corr_cnt", corr_cnt, exp_corr);
        chk("uncorr_cnt", uncorr_cnt, exp_uncorr);
        chk("last_uncorr_addr", last_uncorr_addr, exp_last);
        chk("uncorr_flag", uncorr_flag, exp_flag);
    endtask

    initial begin : model_and_compare
        forever begin
            @(negedge tbec_clk);
            if (tbec_rst) model_reset();
            compare();
            @(posedge tbec_clk);
            if (tbec_rst) begin
                model_reset();
            end else if (plan.size() != 0) begin
                rec_t r;
                r = plan.pop_front();
                // EVAL's verdict is booked even when abort arrives with it
                if (r.eval) begin
                    if (r.code == 2'b01 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
                    if (r.code[1]) begin
                        if (exp_uncorr != 16'hFFFF) exp_uncorr = exp_uncorr + 16'd1;
                        exp_last = r.addr;
                        exp_flag = 1'b1;
                    end
                end
                if (abort) plan.delete();
            end else if (start && !abort) begin
                exp_corr = 16'h0000;
                exp_uncorr = 16'h0000;
                build_plan();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge tbec_clk);
        #1;
    endtask

    task automatic backdoor(input logic [7:0] a, input logic [15:0] d, input logic [1:0] e);
        bd_valid = 1'b1; bd_addr = a; bd_data = d; bd_err = e;
        tick();
        bd_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        host_bus.host_we = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic rand_host();
        host_bus.host_addr  = 8'($urandom_range(0, 255));
        host_bus.host_we    = ($urandom_range(0, 3) == 0);
        host_bus.host_wdata = 16'($urandom);
    endtask

    // Waits for done after a start pulse; k = cycles from acceptance to done.
    task automatic run_to_done(output int k);
        k = 0;
        while (k < 3000) begin
            @(negedge tbec_clk);
            k++;
            if (done) break;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles", k);
        end
        tick();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k, w0, d0, cyc;
        host_bus.host_addr = 8'h00; host_bus.host_we = 1'b0; host_bus.host_wdata = 16'h0000;
        // fill memory with clean random words while in reset
        for (int i = 0; i < NADDR; i++) backdoor(8'(i), 16'($urandom), 2'b00);
        tbec_rst = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", host_bus.host_gnt, 1'b1);
        chk("rst_corr", corr_cnt, 16'h0000);

        // all-clean pass: 256 * (RL+3) busy cycles, then DONE
        w0 = n_writes;
        pulse_start();
        run_to_done(k);
        chk("clean_cycles", k, 32'd1025);
        chk("clean_writes", n_writes - w0, 32'd0);
        chk("clean_corr", corr_cnt, 16'h0000);
        chk("clean_uncorr", uncorr_cnt, 16'h0000);

        // single correctable word at 8'h01
        backdoor(8'h01, 16'hE1F0, 2'b01);
        w0 = n_writes;
        pulse_start();
        run_to_done(k);
        chk("corr_cycles", k, 32'd1026);
        chk("corr_writes", n_writes - w0, 32'd1);
        chk("corr_wr_addr", last_wr_addr, 8'h01);
        chk("corr_wr_data", last_wr_data, 16'hE1F0);
        chk("corr_cnt_lit", corr_cnt, 16'h0001);
        host_bus.host_addr = 8'h01; host_bus.host_we = 1'b0;
        tick();
        chk("host_rd_data", mem_bus.data_out, 16'hE1F0);
        chk("host_rd_code", mem_bus.out_error_code, 2'b00);

        // uncorrectable word at 8'h07
        backdoor(8'h07, 16'h7777, 2'b10);
        w0 = n_writes;
        pulse_start();
        run_to_done(k);
        chk("uncorr_writes", n_writes - w0, 32'd0);
        chk("uncorr_cnt_lit", uncorr_cnt, 16'h0001);
        chk("uncorr_last", last_uncorr_addr, 8'h07);
        chk("uncorr_flag_lit", uncorr_flag, 1'b1);
        backdoor(8'h07, 16'h7777, 2'b00);

        // abort during write-back at 8'h02
        backdoor(8'h02, 16'h1234, 2'b01);
        w0 = n_writes; d0 = done_seen;
        pulse_start();
        k = 0;
        while (k < 100) begin
            @(negedge tbec_clk);
            k++;
            if (mem_bus.mem_we) break;
        end
        chk("wb_seen", mem_bus.mem_we, 1'b1);
        chk("wb_addr", mem_bus.tbec_addr, 8'h02);
        chk("wb_data", mem_bus.data_in, 16'h1234);
        abort = 1'b1;
        @(posedge tbec_clk); #1;
        abort = 1'b0;
        chk("abort_write", n_writes - w0, 32'd1);
        @(negedge tbec_clk);
        chk("abort_busy", busy, 1'b0);
        repeat (20) tick();
        chk("abort_no_done", done_seen - d0, 32'd0);
        chk("abort_corr", corr_cnt, 16'h0001);

        // host write while busy is blocked, in IDLE it lands
        pulse_start();
        repeat (10) tick();
        host_bus.host_addr = 8'h01; host_bus.host_we = 1'b1; host_bus.host_wdata = 16'hBBCC;
        #1;
        chk("busy_gnt", host_bus.host_gnt, 1'b0);
        tick();
        host_bus.host_we = 1'b0;
        chk("busy_mem_kept", mem_arr[1], 16'hE1F0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        host_bus.host_addr = 8'h01; host_bus.host_we = 1'b1; host_bus.host_wdata = 16'hBBCC;
        tick();
        host_bus.host_we = 1'b0;
        chk("idle_host_write", mem_arr[1], 16'hBBCC);

        // reset during WAIT at 8'h10, then restart from address 0
        pulse_start();
        k = 0;
        while (k < 200) begin
            @(negedge tbec_clk);
            k++;
            if (busy && mem_bus.tbec_addr == 8'h10) break;
        end
        chk("rd_10_seen", mem_bus.tbec_addr, 8'h10);
        @(negedge tbec_clk);
        #2 tbec_rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_gnt", host_bus.host_gnt, 1'b1);
        chk("rst_mid_we", mem_bus.mem_we, 1'b0);
        chk("rst_mid_corr", corr_cnt, 16'h0000);
        chk("rst_mid_flag", uncorr_flag, 1'b0);
        @(posedge tbec_clk); #1;
        tbec_rst = 1'b0;
        pulse_start();
        @(negedge tbec_clk);
        chk("restart_addr", mem_bus.tbec_addr, 8'h00);
        chk("restart_busy", busy, 1'b1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // randomized passes: random errors, host traffic, stray starts, rare aborts
        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                backdoor(8'($urandom_range(0, 255)), 16'($urandom), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(3, 20)) begin
                rand_host();
                abort = ($urandom_range(0, 9) == 0);
                tick();
            end
            host_bus.host_we = 1'b0; abort = 1'b0;
            if (p == 1) begin
                start = 1'b1; abort = 1'b1;
                tick();
                start = 1'b0; abort = 1'b0;
            end
            pulse_start();
            cyc = 0;
            while (plan.size() != 0 && cyc < 2000) begin
                rand_host();
                start = ($urandom_range(0, 19) == 0);
                if (start) host_bus.host_we = 1'b0;
                abort = (p >= 3) && ($urandom_range(0, 799) == 0);
                tick();
                cyc++;
            end
            start = 1'b0; abort = 1'b0; host_bus.host_we = 1'b0;
            if (plan.size() != 0) begin
                n_vec++; n_fail++;
                $display("FAIL pass_timeout: pass %0d still running after %0d cycles", p, cyc);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
